shift_reg_univ: RTL and testbench

Parametrised successor to the 8-bit parallel-in/parallel-out register. It adds a serial shift engine so one block handles both parallel staging and serial transfer of a word. Serial transfer is full duplex: shift out on o_Serial and shift in from i_Serial at the same time, paced by a bit-enable strobe. It sits between the byte-level control logic and the SPI-style serial link to the nRF radio, and produces a one-cycle completion pulse per word.

---
 rtl/shreg_pkg.sv | 20 ++
 rtl/bit_counter.sv | 29 ++
 rtl/shift_reg_univ.sv | 112 +++++++++++
 tb/tb_shift_reg_univ.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: state encoding and
// the bit-counter width derivation.
package shreg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // One extra bit so the counter can hold the full word width itself.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Enabled up-counter with synchronous clear and a terminal-count flag that
// fires on the increment that reaches TERM.
module bit_counter #(
    parameter int CNT_W = 4,
    parameter int TERM  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TERM - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = en && (cnt == TERM_M1);

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load/readback plus a full-duplex serial
// engine paced by a bit strobe. Optional registered parity: SHREG_PARITY_EN.
module shift_reg_univ
    import shreg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = cnt_w(WIDTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Ld,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Start,
    input  logic             i_Shift_En,
    input  logic             i_Serial,
    output logic             o_Serial,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Busy,
    output logic             o_Done,
`ifdef SHREG_PARITY_EN
    output logic             o_Parity,
`endif
    output logic [CNT_W-1:0] o_Bit_Cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load_en;
    logic             start_acc;
    logic             shift_en;
    logic             last_shift;

    assign load_en   = (state_q == S_IDLE) && i_Ld;
    assign start_acc = (state_q == S_IDLE) && i_Start;
    assign shift_en  = (state_q == S_SHIFT) && i_Shift_En;

    bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (WIDTH)
    ) u_bit_counter (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .clr   (start_acc),
        .en    (shift_en),
        .cnt   (o_Bit_Cnt),
        .tc    (last_shift)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_Start) state_d = S_SHIFT;
            S_SHIFT: if (last_shift) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A simultaneous load and start lands the new word before the first shift.
    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = i_Data;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                data_d = {data_q[WIDTH-2:0], i_Serial};
            end else begin
                data_d = {i_Serial, data_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_Serial = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];
    assign o_Data   = data_q;
    assign o_Busy   = (state_q == S_SHIFT);
    assign o_Done   = (state_q == S_DONE);

`ifdef SHREG_PARITY_EN
    logic parity_q;

    // Parity of the word being latched, so it is valid alongside o_Done.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            parity_q <= 1'b0;
        end else if (load_en || last_shift) begin
            parity_q <= ^data_d;
        end
    end

    assign o_Parity = parity_q;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: an MSB-first and an LSB-first instance
// share stimulus; expected serial bits and received words are queued per shift.
module tb_shift_reg_univ;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld;
    logic [W-1:0]  data;
    logic          start;
    logic          shift_en;
    logic          ser;

    logic          m_ser, l_ser, m_busy, l_busy, m_done, l_done;
    logic [W-1:0]  m_data, l_data;
    logic [CW-1:0] m_cnt, l_cnt;
`ifdef SHREG_PARITY_EN
    logic          m_par, l_par;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic          q_mbit[$];
    logic          q_lbit[$];
    logic [W-1:0]  q_mword[$];
    logic [W-1:0]  q_lword[$];

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Ld(ld), .i_Data(data), .i_Start(start),
        .i_Shift_En(shift_en), .i_Serial(ser), .o_Serial(m_ser), .o_Data(m_data),
        .o_Busy(m_busy), .o_Done(m_done),
`ifdef SHREG_PARITY_EN
        .o_Parity(m_par),
`endif
        .o_Bit_Cnt(m_cnt)
    );

    shift_reg_univ #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Ld(ld), .i_Data(data), .i_Start(start),
        .i_Shift_En(shift_en), .i_Serial(ser), .o_Serial(l_ser), .o_Data(l_data),
        .o_Busy(l_busy), .o_Done(l_done),
`ifdef SHREG_PARITY_EN
        .o_Parity(l_par),
`endif
        .o_Bit_Cnt(l_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] reverse(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whenever a DUT shifts a bit out or signals completion.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_busy && shift_en) begin
                if (q_mbit.size() == 0) chk("m_serial_unexpected", 32'(m_ser), 32'hx);
                else chk("m_serial", 32'(m_ser), 32'(q_mbit.pop_front()));
            end
            if (l_busy && shift_en) begin
                if (q_lbit.size() == 0) chk("l_serial_unexpected", 32'(l_ser), 32'hx);
                else chk("l_serial", 32'(l_ser), 32'(q_lbit.pop_front()));
            end
            if (m_done) begin
                chk("m_done_cnt", 32'(m_cnt), 32'(W));
                if (q_mword.size() == 0) chk("m_done_unexpected", 32'(m_data), 32'hx);
                else chk("m_word", 32'(m_data), 32'(q_mword.pop_front()));
            end
            if (l_done) begin
                chk("l_done_cnt", 32'(l_cnt), 32'(W));
                if (q_lword.size() == 0) chk("l_done_unexpected", 32'(l_data), 32'hx);
                else chk("l_word", 32'(l_data), 32'(q_lword.pop_front()));
            end
        end
    end

    // One word: optional separate load, start, W strobed shifts with gaps,
    // optional mid-word load/start injection, then DONE timing checks.
    task automatic do_transfer(input logic [W-1:0] w, input logic [W-1:0] s,
                               input int gap, input bit combined, input bit inject);
        int g;
        if (!combined) begin
            ld = 1'b1; data = w;
            step();
            ld = 1'b0;
            chk("load_m_data", 32'(m_data), 32'(w));
            chk("load_busy", 32'(m_busy), 32'd0);
            chk("load_done", 32'(m_done), 32'd0);
`ifdef SHREG_PARITY_EN
            chk("load_parity", 32'(m_par), 32'(^w));
`endif
        end
        ld = combined; data = w; start = 1'b1;
        step();
        ld = 1'b0; start = 1'b0;
        chk("start_m_data", 32'(m_data), 32'(w));
        chk("start_l_data", 32'(l_data), 32'(w));
        chk("start_busy", 32'(m_busy & l_busy), 32'd1);
        chk("start_cnt", 32'(m_cnt), 32'd0);
        for (int k = 0; k < W; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int j = 0; j < g; j++) begin
                ser = 1'(($urandom() & 1));
                step();
            end
            if (inject && k == 3) begin
                ld = 1'b1; data = 8'hFF; start = 1'b1;
            end
            shift_en = 1'b1;
            ser = s[W-1-k];
            q_mbit.push_back(w[W-1-k]);
            q_lbit.push_back(w[k]);
            if (k == W - 1) begin
                q_mword.push_back(s);
                q_lword.push_back(reverse(s));
            end
            step();
            shift_en = 1'b0; ld = 1'b0; start = 1'b0;
            if (k < W - 1) chk("mid_cnt", 32'(m_cnt), 32'(k + 1));
        end
        chk("done_pulse", 32'({m_done, l_done}), 32'd3);
        chk("done_busy", 32'({m_busy, l_busy}), 32'd0);
        chk("done_l_cnt", 32'(l_cnt), 32'(W));
`ifdef SHREG_PARITY_EN
        chk("done_m_parity", 32'(m_par), 32'(^s));
        chk("done_l_parity", 32'(l_par), 32'(^s));
`endif
        step();
        chk("done_one_cycle", 32'({m_done, l_done}), 32'd0);
        chk("idle_m_data", 32'(m_data), 32'(s));
        chk("idle_l_data", 32'(l_data), 32'(reverse(s)));
        chk("idle_cnt_hold", 32'(m_cnt), 32'(W));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ld = 1'b0; data = '0; start = 1'b0; shift_en = 1'b0; ser = 1'b0;
        #1;
        chk("rst_data", 32'(m_data | l_data), 32'd0);
        chk("rst_flags", 32'({m_busy, m_done, l_busy, l_done, m_ser, l_ser}), 32'd0);
        chk("rst_cnt", 32'(m_cnt | l_cnt), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Shift strobe in IDLE must not move the register.
        ld = 1'b1; data = 8'hAC;
        step();
        ld = 1'b0; shift_en = 1'b1; ser = 1'b1;
        step();
        shift_en = 1'b0;
        chk("idle_shift_ignored", 32'(m_data), 32'h00AC);
        chk("idle_shift_busy", 32'(m_busy), 32'd0);

        do_transfer(8'hAC, 8'h55, 0, 1'b0, 1'b0);
        do_transfer(8'hAC, 8'h55, 1, 1'b0, 1'b0);
        do_transfer(8'hAC, 8'h55, 0, 1'b0, 1'b1);
        do_transfer(8'h3C, 8'h07, 0, 1'b1, 1'b0);

        // Asynchronous reset part-way through a word.
        ld = 1'b1; data = 8'hAC; start = 1'b1;
        step();
        ld = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            shift_en = 1'b1; ser = 1'b1;
            q_mbit.push_back(data[W-1-k]);
            q_lbit.push_back(data[k]);
            step();
        end
        shift_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(m_data | l_data), 32'd0);
        chk("arst_busy", 32'({m_busy, l_busy}), 32'd0);
        chk("arst_cnt", 32'(m_cnt | l_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst_no_done", 32'({m_done, l_done, m_busy}), 32'd0);
        end

        for (int t = 0; t < 24; t++) begin
            do_transfer(8'($urandom()), 8'($urandom()), -1, 1'($urandom() & 1), 1'($urandom() & 1));
        end

        step(); step();
        chk("sb_bits_drained", 32'(q_mbit.size() + q_lbit.size()), 32'd0);
        chk("sb_words_drained", 32'(q_mword.size() + q_lword.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
